fill_word_checker: RTL and testbench
====================================

// Module: fill_word_checker
// PURPOSE
// - Stream stage that consumes 4-state fill words: the '0, '1, 'x, 'z replicated-constant words produced upstream.
// - Classifies each word as ZERO, ONES, ALLX, ALLZ or MIXED.
// - Keeps saturating per-class counts and checks the repeating order ZERO->ONES->ALLX->ALLZ.
// - Words use 2-plane encoding: (unk=0, data=v) is known bit v; (unk=1, data=0) is X; (unk=1, data=1) is Z.
// PARAMETERS
// - W      32  word width in bits (>=1)
// - CNT_W  16  width of each class counter (>=2)
// PORTS
// - clk        in   1      single clock, rising edge
// - rst_n      in   1      asynchronous active-low reset
// - clear      in   1      sync clear of counters, seq_err and order FSM
// - in_valid   in   1      input word valid
// - in_ready   out  1      stage can accept this cycle
// - in_data    in   W      data plane
// - in_unk     in   W      unknown plane
// - out_valid  out  1      classified result valid
// - out_ready  in   1      downstream accepts result
// - out_class  out  3      fill_pkg::fill_class_e of held word
// - cnt_zero   out  CNT_W  accepted ZERO words
// - cnt_ones   out  CNT_W  accepted ONES words
// - cnt_x      out  CNT_W  accepted ALLX words
// - cnt_z      out  CNT_W  accepted ALLZ words
// - cnt_mixed  out  CNT_W  accepted MIXED words
// - seq_err    out  1      sticky order violation
// BEHAVIOUR
// - Reset (rst_n=0, async): out_valid=0, out_class=FC_ZERO, all cnt_*=0, seq_err=0, FSM=EXP_ZERO.
// - Accept: acc = in_valid & in_ready.
//   - in_ready = !out_valid | out_ready (combinational); full throughput, no bubbles.
// - Latency: a word accepted in cycle N appears on out_class/out_valid in cycle N+1.
//   - out_class holds stable while out_valid & !out_ready.
// - Classification, first match wins:
//   - ZERO: unk==0 & data==0
//   - ONES: unk==0 & data=='1
//   - ALLX: unk=='1 & data==0
//   - ALLZ: unk=='1 & data=='1
//   - MIXED: anything else
// - Counters: on acc, the counter of the word's class increments by 1.
//   - Saturates at 2**CNT_W-1; no wrap.
//   - Counter update is visible in cycle N+1.
// - Order FSM states: EXP_ZERO, EXP_ONES, EXP_X, EXP_Z.
//   - On acc with class == expected: advance; EXP_Z wraps to EXP_ZERO.
//   - On acc with class != expected: set seq_err.
//     - Resync: next state = successor of the received class.
//     - MIXED resyncs to EXP_ZERO.
//   - No acc: FSM holds.
// - clear: takes effect at the next edge.
//   - All cnt_*=0, seq_err=0, FSM=EXP_ZERO.
//   - A word accepted in the same cycle is still forwarded to the output, but is neither counted nor order-checked.
//   - clear does not touch out_valid/out_class.
// - Simultaneous out_ready and acc: the held result retires and the new one loads in the same edge; out_valid stays 1.
// - Reset mid-stream: the held result is discarded, no output handshake completes, and counts restart at 0.
// - Input must hold stable while in_valid & !in_ready; the block does not check this.
// STRUCTURE
// - fill_pkg (shared):
//   - typedef enum logic[2:0] fill_class_e {FC_ZERO, FC_ONES, FC_X, FC_Z, FC_MIXED}
//   - typedef enum logic[1:0] fill_exp_e {EXP_ZERO, EXP_ONES, EXP_X, EXP_Z}
//   - function fill_classify(data, unk)
// - Sub-module fill_pipe_reg: one-entry valid/ready pipeline register holding the class, parameterised by payload width.
// - Counters, saturation and FSM sit in the top.
// TESTING
// - Reset mid-stream:
//   - Stimulus: pulse rst_n low while out_valid=1 and cnt_ones=5.
//   - Required: out_valid drops asynchronously, all cnt_*=0, seq_err=0.
//   - First word after reset is checked against EXP_ZERO.
// - Ordered stream:
//   - Stimulus: send 00000000/0, FFFFFFFF/0, 00000000/FFFFFFFF, FFFFFFFF/FFFFFFFF twice, with out_ready=1.
//   - Required: each cnt_zero/ones/x/z = 2, seq_err = 0.
//   - out_class sequence: 0,1,2,3,0,1,2,3, one cycle after each accept.
// - Mixed word:
//   - Stimulus: data=0000_0001, unk=0 when EXP_ZERO.
//   - Required: out_class=FC_MIXED, cnt_mixed=1, seq_err=1, FSM=EXP_ZERO.
// - Backpressure:
//   - Stimulus: out_ready=0 for 3 cycles with in_valid=1.
//   - Required: in_ready=0 after the first accept, out_class stable, only 1 word counted.
//   - Releasing out_ready gives back-to-back transfers.
// - Saturation:
//   - Stimulus: CNT_W=2, send 5 ZERO words.
//   - Required: cnt_zero = 3 and holds there.
// - clear + accept in the same cycle:
//   - Stimulus: clear=1 during an ONES accept with cnt_ones=4 and seq_err=1.
//   - Required: next cycle cnt_ones=0, seq_err=0, FSM=EXP_ZERO, out_class=FC_ONES, out_valid=1.

Source files
------------

// File: rtl/fill_pkg.sv
// Shared types and helpers for the fill-word checker: word classes, order-FSM states.
// Latency: n/a (pure types and combinational functions).
// Backpressure: n/a.
package fill_pkg;

   typedef enum logic [2:0] {
      FC_ZERO  = 3'd0,
      FC_ONES  = 3'd1,
      FC_X     = 3'd2,
      FC_Z     = 3'd3,
      FC_MIXED = 3'd4
   } fill_class_e;

   typedef enum logic [1:0] {
      EXP_ZERO = 2'd0,
      EXP_ONES = 2'd1,
      EXP_X    = 2'd2,
      EXP_Z    = 2'd3
   } fill_exp_e;

   localparam int FILL_NUM_CLASSES = 5;

   // Takes the plane reductions rather than the planes themselves so the
   // function stays independent of the word width. First match wins.
   function automatic fill_class_e fill_classify(input logic data_zero,
                                                 input logic data_ones,
                                                 input logic unk_zero,
                                                 input logic unk_ones);
      fill_class_e c;
      if (unk_zero && data_zero)      c = FC_ZERO;
      else if (unk_zero && data_ones) c = FC_ONES;
      else if (unk_ones && data_zero) c = FC_X;
      else if (unk_ones && data_ones) c = FC_Z;
      else                            c = FC_MIXED;
      return c;
   endfunction

   // The expected class after receiving a given class. Used both for the
   // in-order advance and for resync after a violation; MIXED restarts the cycle.
   function automatic fill_exp_e fill_successor(input fill_class_e c);
      fill_exp_e e;
      case (c)
         FC_ZERO: e = EXP_ONES;
         FC_ONES: e = EXP_X;
         FC_X:    e = EXP_Z;
         default: e = EXP_ZERO;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/fill_pipe_reg.sv
// One-entry valid/ready pipeline register carrying a W-bit payload.
// Latency: 1 cycle from accept to out_valid; full throughput.
// Backpressure: in_ready = !out_valid | out_ready; payload holds while stalled.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream.
module fill_pipe_reg #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   // Retire and load can happen on the same edge, so no bubble between words.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (in_ready) begin
            out_valid <= in_valid;
         end
         if (in_valid && in_ready) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/fill_word_checker.sv
// Classifies 2-plane fill words, keeps saturating per-class counts, checks ZERO->ONES->X->Z order.
// Latency: class on out_class 1 cycle after accept; counters/seq_err also update 1 cycle after accept.
// Backpressure: single output register; in_ready = !out_valid | out_ready, no bubbles.
// Ports: clk, rst_n (async active-low), clear (sync clear of counts/seq_err/FSM);
//        in_valid/in_ready/in_data/in_unk input stream; out_valid/out_ready/out_class result;
//        cnt_zero/cnt_ones/cnt_x/cnt_z/cnt_mixed counters; seq_err sticky order violation.
module fill_word_checker
   import fill_pkg::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic [W-1:0]     in_unk,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_class,
   output logic [CNT_W-1:0] cnt_zero,
   output logic [CNT_W-1:0] cnt_ones,
   output logic [CNT_W-1:0] cnt_x,
   output logic [CNT_W-1:0] cnt_z,
   output logic [CNT_W-1:0] cnt_mixed,
   output logic             seq_err
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   fill_class_e      cls;
   logic             acc;
   logic [CNT_W-1:0] cnt_q [FILL_NUM_CLASSES];
   fill_exp_e        exp_q, exp_d;
   logic             seq_err_q, seq_err_d;

   assign cls = fill_classify(~|in_data, &in_data, ~|in_unk, &in_unk);
   assign acc = in_valid && in_ready;

   fill_pipe_reg #(
      .W(3)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (cls),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_class)
   );

   // A word accepted together with clear is forwarded but not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FILL_NUM_CLASSES; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < FILL_NUM_CLASSES; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (acc && (cnt_q[cls] != CNT_MAX)) begin
         cnt_q[cls] <= cnt_q[cls] + CNT_ONE;
      end
   end

   assign cnt_zero  = cnt_q[FC_ZERO];
   assign cnt_ones  = cnt_q[FC_ONES];
   assign cnt_x     = cnt_q[FC_X];
   assign cnt_z     = cnt_q[FC_Z];
   assign cnt_mixed = cnt_q[FC_MIXED];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q     <= EXP_ZERO;
         seq_err_q <= 1'b0;
      end else begin
         exp_q     <= exp_d;
         seq_err_q <= seq_err_d;
      end
   end

   // Both the in-order advance and the resync after a violation land on the
   // successor of the received class, so only the error flag depends on the match.
   always_comb begin
      exp_d     = exp_q;
      seq_err_d = seq_err_q;
      if (clear) begin
         exp_d     = EXP_ZERO;
         seq_err_d = 1'b0;
      end else if (acc) begin
         if (cls != {1'b0, exp_q}) begin
            seq_err_d = 1'b1;
         end
         exp_d = fill_successor(cls);
      end
   end

   assign seq_err = seq_err_q;

endmodule

// File: tb/tb_fill_word_checker.sv
// Directed self-checking bench for fill_word_checker (W=32, CNT_W=16) plus a CNT_W=2 instance.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven per scenario.
module tb_fill_word_checker;
   import fill_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, clear, in_valid, out_ready;
   logic [31:0] in_data, in_unk;
   logic        in_ready, out_valid, seq_err;
   logic [2:0]  out_class;
   logic [15:0] cnt_zero, cnt_ones, cnt_x, cnt_z, cnt_mixed;
   logic        s_in_ready, s_out_valid, s_seq_err;
   logic [2:0]  s_out_class;
   logic [1:0]  s_cnt_zero, s_cnt_ones, s_cnt_x, s_cnt_z, s_cnt_mixed;

   int checks = 0;
   int errors = 0;

   logic [31:0] tab_d [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
   logic [31:0] tab_u [4] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

   always #5 clk = ~clk;

   fill_word_checker #(.W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_unk(in_unk),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
      .cnt_zero(cnt_zero), .cnt_ones(cnt_ones), .cnt_x(cnt_x), .cnt_z(cnt_z),
      .cnt_mixed(cnt_mixed), .seq_err(seq_err)
   );

   fill_word_checker #(.W(32), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_unk(in_unk),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_class(s_out_class),
      .cnt_zero(s_cnt_zero), .cnt_ones(s_cnt_ones), .cnt_x(s_cnt_x), .cnt_z(s_cnt_z),
      .cnt_mixed(s_cnt_mixed), .seq_err(s_seq_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] u);
      in_valid = v;
      in_data  = d;
      in_unk   = u;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      checks++; if (out_class !== 3'd0) begin errors++; $display("FAIL reset_out_class: got %0d want 0", out_class); end
      checks++; if ({cnt_zero, cnt_ones, cnt_x, cnt_z, cnt_mixed} !== 80'd0) begin errors++; $display("FAIL reset_counts: got %0d %0d %0d %0d %0d want all 0", cnt_zero, cnt_ones, cnt_x, cnt_z, cnt_mixed); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %0b want 0", seq_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_ordered();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, tab_d[i%4], tab_u[i%4]);
         step();
         checks++; if (out_valid !== 1'b1 || out_class !== 3'(i % 4)) begin errors++; $display("FAIL ordered_class[%0d]: got v=%0b c=%0d want v=1 c=%0d", i, out_valid, out_class, i % 4); end
      end
      drive(1'b0, 32'h0, 32'h0);
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ordered_drain: got out_valid=%0b want 0", out_valid); end
      checks++; if (cnt_zero !== 16'd2 || cnt_ones !== 16'd2 || cnt_x !== 16'd2 || cnt_z !== 16'd2) begin errors++; $display("FAIL ordered_counts: got %0d %0d %0d %0d want 2 2 2 2", cnt_zero, cnt_ones, cnt_x, cnt_z); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL ordered_seq_err: got %0b want 0", seq_err); end
   endtask

   task automatic test_mixed();
      drive(1'b1, 32'h0000_0001, 32'h0);
      step();
      drive(1'b0, 32'h0, 32'h0);
      checks++; if (out_class !== 3'd4) begin errors++; $display("FAIL mixed_class: got %0d want 4", out_class); end
      checks++; if (cnt_mixed !== 16'd1 || cnt_zero !== 16'd2) begin errors++; $display("FAIL mixed_counts: got mixed=%0d zero=%0d want 1 2", cnt_mixed, cnt_zero); end
      checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL mixed_seq_err: got %0b want 1", seq_err); end
      checks++; if (dut.exp_q !== EXP_ZERO) begin errors++; $display("FAIL mixed_fsm: got %0d want 0", dut.exp_q); end
      step();
   endtask

   task automatic test_backpressure();
      clear = 1'b1; step(); clear = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 32'h0, 32'h0);
      step();
      drive(1'b1, 32'hFFFF_FFFF, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_class !== 3'd0) begin errors++; $display("FAIL bp_stall[%0d]: got rdy=%0b v=%0b c=%0d want 0 1 0", i, in_ready, out_valid, out_class); end
         checks++; if (cnt_zero !== 16'd1 || cnt_ones !== 16'd0) begin errors++; $display("FAIL bp_count[%0d]: got zero=%0d ones=%0d want 1 0", i, cnt_zero, cnt_ones); end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %0b want 1", in_ready); end
      for (int i = 1; i < 4; i++) begin
         step();
         checks++; if (out_valid !== 1'b1 || out_class !== 3'(i)) begin errors++; $display("FAIL bp_b2b[%0d]: got v=%0b c=%0d want 1 %0d", i, out_valid, out_class, i); end
         if (i < 3) drive(1'b1, tab_d[i+1], tab_u[i+1]);
         else drive(1'b0, 32'h0, 32'h0);
      end
      step();
      checks++; if (cnt_zero !== 16'd1 || cnt_ones !== 16'd1 || cnt_x !== 16'd1 || cnt_z !== 16'd1 || seq_err !== 1'b0) begin errors++; $display("FAIL bp_final: got %0d %0d %0d %0d err=%0b want 1 1 1 1 0", cnt_zero, cnt_ones, cnt_x, cnt_z, seq_err); end
   endtask

   task automatic test_saturation();
      int e;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         e = (i < 3) ? i + 1 : 3;
         checks++; if (s_cnt_zero !== 2'(e)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, s_cnt_zero, e); end
      end
      drive(1'b0, 32'h0, 32'h0);
      step();
      checks++; if (s_cnt_zero !== 2'd3 || s_seq_err !== 1'b1) begin errors++; $display("FAIL sat_hold: got cnt=%0d err=%0b want 3 1", s_cnt_zero, s_seq_err); end
      checks++; if (cnt_zero !== 16'd5) begin errors++; $display("FAIL sat_wide: got %0d want 5", cnt_zero); end
   endtask

   task automatic test_clear_accept();
      clear = 1'b1; step(); clear = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 32'hFFFF_FFFF, 32'h0);
      for (int i = 0; i < 4; i++) step();
      checks++; if (cnt_ones !== 16'd4 || seq_err !== 1'b1) begin errors++; $display("FAIL clr_pre: got ones=%0d err=%0b want 4 1", cnt_ones, seq_err); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++; if (cnt_ones !== 16'd0 || seq_err !== 1'b0) begin errors++; $display("FAIL clr_counts: got ones=%0d err=%0b want 0 0", cnt_ones, seq_err); end
      checks++; if (dut.exp_q !== EXP_ZERO) begin errors++; $display("FAIL clr_fsm: got %0d want 0", dut.exp_q); end
      checks++; if (out_valid !== 1'b1 || out_class !== 3'd1) begin errors++; $display("FAIL clr_out: got v=%0b c=%0d want 1 1", out_valid, out_class); end
      drive(1'b1, 32'h0, 32'h0);
      step();
      drive(1'b0, 32'h0, 32'h0);
      checks++; if (seq_err !== 1'b0 || cnt_zero !== 16'd1 || out_class !== 3'd0) begin errors++; $display("FAIL clr_after: got err=%0b zero=%0d c=%0d want 0 1 0", seq_err, cnt_zero, out_class); end
      step();
   endtask

   task automatic test_reset_midstream();
      clear = 1'b1; step(); clear = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 32'hFFFF_FFFF, 32'h0);
      for (int i = 0; i < 5; i++) step();
      drive(1'b0, 32'h0, 32'h0);
      out_ready = 1'b0;
      checks++; if (cnt_ones !== 16'd5 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got ones=%0d v=%0b want 5 1", cnt_ones, out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
      checks++; if ({cnt_zero, cnt_ones, cnt_x, cnt_z, cnt_mixed} !== 80'd0 || seq_err !== 1'b0) begin errors++; $display("FAIL mid_counts: got %0d %0d %0d %0d %0d err=%0b want 0s", cnt_zero, cnt_ones, cnt_x, cnt_z, cnt_mixed, seq_err); end
      #1 rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      drive(1'b1, 32'h0, 32'h0);
      step();
      drive(1'b1, 32'hFFFF_FFFF, 32'h0);
      step();
      drive(1'b0, 32'h0, 32'h0);
      checks++; if (seq_err !== 1'b0 || cnt_zero !== 16'd1 || cnt_ones !== 16'd1 || out_class !== 3'd1) begin errors++; $display("FAIL mid_after: got err=%0b zero=%0d ones=%0d c=%0d want 0 1 1 1", seq_err, cnt_zero, cnt_ones, out_class); end
      step();
   endtask

   initial begin
      test_reset();
      test_ordered();
      test_mixed();
      test_backpressure();
      test_saturation();
      test_clear_accept();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
